fsm_enchimento_multicanal: RTL and testbench

//   Multi-channel successor of the single-valve fill controller. Drives N fill valves in parallel,
//   one Moore FSM per channel. Adds three features: a debounced level sensor, a per-channel fill

---
 rtl/fsm_enchimento_multicanal.sv | 213 +++++++++++++++++++++
 tb/tb_fsm_enchimento_multicanal.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_enchimento_multicanal.sv
`default_nettype none
// ============================================================================
// Module      : fsm_enchimento_multicanal
// Description : Multi-channel fill-valve controller. One Moore FSM per
//               channel (IDLE / ENCHENDO / CHEIO / ERRO) with a debounced
//               level sensor, a per-channel fill timeout and abort on
//               withdrawal of cmd_iniciar. Answers the master sequencer's
//               cmd_iniciar / tarefa_concluida handshake.
// Ports       :
//   clk              in   system clock
//   reset            in   asynchronous, active-high reset
//   cmd_iniciar      in   master request, held high for the whole fill cycle
//   canal_habilitado in   channel enable mask, latched at cycle start
//   sensor_nivel     in   raw level sensors, 1 = full
//   valvula_ativa    out  valve drive per channel
//   tarefa_concluida out  every latched channel is full or in error
//   erro_timeout     out  OR of the per-channel error flags
//   canal_erro       out  per-channel timeout flag
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module fsm_enchimento_multicanal #(
  parameter int N_CANAIS        = 4,
  parameter int DEBOUNCE_CICLOS = 16,
  parameter int TIMEOUT_CICLOS  = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_iniciar,
  input  logic [N_CANAIS-1:0] canal_habilitado,
  input  logic [N_CANAIS-1:0] sensor_nivel,
  output logic [N_CANAIS-1:0] valvula_ativa,
  output logic                tarefa_concluida,
  output logic                erro_timeout,
  output logic [N_CANAIS-1:0] canal_erro
);

  localparam int C_DEB_W = $clog2(DEBOUNCE_CICLOS);
  localparam int C_TMO_W = $clog2(TIMEOUT_CICLOS);

  localparam logic [C_DEB_W-1:0] C_DEB_LAST = C_DEB_W'(DEBOUNCE_CICLOS - 1);
  localparam logic [C_DEB_W-1:0] C_DEB_MAX  = '1;
  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT_CICLOS - 1);
  localparam logic [C_TMO_W-1:0] C_TMO_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENCHENDO = 2'd1,
    CHEIO    = 2'd2,
    ERRO     = 2'd3
  } estado_t;

  // Per-channel state decodes, gathered for the shared logic below.
  logic [N_CANAIS-1:0] ocioso;
  logic [N_CANAIS-1:0] enchendo;
  logic [N_CANAIS-1:0] em_erro;
  logic [N_CANAIS-1:0] concluido;

  // --------------------------------------------------------------------------
  // Mask latch: captured on the first edge with cmd_iniciar=1 while every
  // channel is idle, released when cmd_iniciar drops.
  // --------------------------------------------------------------------------
  logic                mask_valid_q, mask_valid_d;
  logic [N_CANAIS-1:0] mask_q, mask_d;
  logic [N_CANAIS-1:0] mascara_efetiva;

  always_comb begin
    mask_valid_d = mask_valid_q;
    mask_d       = mask_q;
    if (!cmd_iniciar) begin
      mask_valid_d = 1'b0;
      mask_d       = '0;
    end else if (!mask_valid_q && (&ocioso)) begin
      mask_valid_d = 1'b1;
      mask_d       = canal_habilitado;
    end
  end

  // On the latching edge the channels must already see the incoming mask so
  // the valve opens one clk after the cmd rise; afterwards only the latched
  // copy counts, so mask changes mid-cycle are ignored.
  always_comb begin
    mascara_efetiva = '0;
    if (mask_valid_q) begin
      mascara_efetiva = mask_q;
    end else if (&ocioso) begin
      mascara_efetiva = canal_habilitado;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_valid_q <= 1'b0;
      mask_q       <= '0;
    end else begin
      mask_valid_q <= mask_valid_d;
      mask_q       <= mask_d;
    end
  end

  // --------------------------------------------------------------------------
  // Channel FSMs
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
    estado_t              estado_q, estado_d;
    logic [C_DEB_W-1:0]   deb_q, deb_d;
    logic [C_TMO_W-1:0]   tmo_q, tmo_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        estado_q <= IDLE;
        deb_q    <= '0;
        tmo_q    <= '0;
      end else begin
        estado_q <= estado_d;
        deb_q    <= deb_d;
        tmo_q    <= tmo_d;
      end
    end

    always_comb begin
      estado_d = estado_q;
      deb_d    = deb_q;
      tmo_d    = tmo_q;
      case (estado_q)
        IDLE: begin
          deb_d = '0;
          tmo_d = '0;
          if (cmd_iniciar && mascara_efetiva[i]) begin
            estado_d = ENCHENDO;
          end
        end
        ENCHENDO: begin
          if (!cmd_iniciar) begin
            // Abort outranks both full and timeout.
            estado_d = IDLE;
            deb_d    = '0;
            tmo_d    = '0;
          end else begin
            if (sensor_nivel[i]) begin
              if (deb_q != C_DEB_MAX) begin
                deb_d = deb_q + 1'b1;
              end
            end else begin
              deb_d = '0;
            end
            if (tmo_q != C_TMO_MAX) begin
              tmo_d = tmo_q + 1'b1;
            end
            // Full is tested first so it wins a same-edge tie with timeout.
            if (sensor_nivel[i] && (deb_q == C_DEB_LAST)) begin
              estado_d = CHEIO;
            end else if (tmo_q == C_TMO_LAST) begin
              estado_d = ERRO;
            end
          end
        end
        CHEIO, ERRO: begin
          if (!cmd_iniciar) begin
            estado_d = IDLE;
            deb_d    = '0;
            tmo_d    = '0;
          end
        end
        default: begin
          estado_d = IDLE;
        end
      endcase
    end

    assign ocioso[i]    = (estado_q == IDLE);
    assign enchendo[i]  = (estado_q == ENCHENDO);
    assign em_erro[i]   = (estado_q == ERRO);
    assign concluido[i] = (estado_q == CHEIO) || (estado_q == ERRO);
  end

  // --------------------------------------------------------------------------
  // Registered outputs (one clk behind the state)
  // --------------------------------------------------------------------------
  logic [N_CANAIS-1:0] valvula_ativa_q, valvula_ativa_d;
  logic [N_CANAIS-1:0] canal_erro_q, canal_erro_d;
  logic                erro_timeout_q, erro_timeout_d;
  logic                tarefa_concluida_q, tarefa_concluida_d;

  always_comb begin
    valvula_ativa_d    = enchendo;
    canal_erro_d       = em_erro;
    erro_timeout_d     = |em_erro;
    // Channels outside the latched mask count as done, so an all-zero mask
    // completes as soon as it is latched.
    tarefa_concluida_d = cmd_iniciar && mask_valid_q && (&(concluido | ~mask_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valvula_ativa_q    <= '0;
      canal_erro_q       <= '0;
      erro_timeout_q     <= 1'b0;
      tarefa_concluida_q <= 1'b0;
    end else begin
      valvula_ativa_q    <= valvula_ativa_d;
      canal_erro_q       <= canal_erro_d;
      erro_timeout_q     <= erro_timeout_d;
      tarefa_concluida_q <= tarefa_concluida_d;
    end
  end

  assign valvula_ativa    = valvula_ativa_q;
  assign canal_erro       = canal_erro_q;
  assign erro_timeout     = erro_timeout_q;
  assign tarefa_concluida = tarefa_concluida_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_enchimento_multicanal.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_enchimento_multicanal
// Description : Self-checking bench for fsm_enchimento_multicanal. Directed
//               fill scenarios followed by randomized fill cycles, all
//               compared against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_enchimento_multicanal;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int TMO = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd;
  logic [N-1:0] hab;
  logic [N-1:0] sens;
  logic [N-1:0] valv;
  logic         tar;
  logic         etmo;
  logic [N-1:0] cerr;

  always #10 clk = ~clk;

  fsm_enchimento_multicanal #(
    .N_CANAIS        (N),
    .DEBOUNCE_CICLOS (DEB),
    .TIMEOUT_CICLOS  (TMO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_iniciar      (cmd),
    .canal_habilitado (hab),
    .sensor_nivel     (sens),
    .valvula_ativa    (valv),
    .tarefa_concluida (tar),
    .erro_timeout     (etmo),
    .canal_erro       (cerr)
  );

  // --------------------------------------------------------------------------
  // Reference model: per channel, whether it is filling / full / in error,
  // how many consecutive full readings it has seen and how long it has been
  // filling. Expected outputs are the previous edge's status.
  // --------------------------------------------------------------------------
  bit         m_latched;
  bit [N-1:0] m_mask, m_fill, m_full, m_err;
  int         m_run [N];
  int         m_age [N];
  bit [N-1:0] e_valv, e_cerr;
  bit         e_tar, e_etmo;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_latched = 1'b0;
    m_mask = '0; m_fill = '0; m_full = '0; m_err = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0;
      m_age[i] = 0;
    end
    e_valv = '0; e_cerr = '0; e_tar = 1'b0; e_etmo = 1'b0;
  endtask

  task automatic model_edge();
    bit all_done;
    all_done = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (m_mask[i] && !(m_full[i] || m_err[i])) all_done = 1'b0;
    end
    e_valv = m_fill;
    e_cerr = m_err;
    e_etmo = |m_err;
    e_tar  = cmd && m_latched && all_done;

    if (!cmd) begin
      m_latched = 1'b0;
      m_mask = '0; m_fill = '0; m_full = '0; m_err = '0;
    end else if (!m_latched) begin
      m_latched = 1'b1;
      m_mask    = hab;
      m_fill    = hab;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0;
        m_age[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_fill[i]) begin
          m_age[i]++;
          m_run[i] = sens[i] ? m_run[i] + 1 : 0;
          if (m_run[i] == DEB) begin
            m_fill[i] = 1'b0;
            m_full[i] = 1'b1;
          end else if (m_age[i] == TMO) begin
            m_fill[i] = 1'b0;
            m_err[i]  = 1'b1;
          end
        end
      end
    end
  endtask

  // Called while clk is low; returns at the following negedge with the
  // outputs of that posedge checked.
  task automatic cycle(input bit c, input logic [N-1:0] h, input logic [N-1:0] s);
    cmd  = c;
    hab  = h;
    sens = s;
    @(posedge clk);
    model_edge();
    #1;
    check_eq("valvula_ativa", valv, e_valv);
    check_eq("canal_erro", cerr, e_cerr);
    check_eq("erro_timeout", etmo, e_etmo);
    check_eq("tarefa_concluida", tar, e_tar);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, '0);
  endtask

  // Sensors rise on ch0 @5, ch1 @8, ch3 @10; ch2 disabled.
  task automatic scen1();
    logic [N-1:0] s;
    for (int t = 0; t < 20; t++) begin
      s = '0;
      s[0] = (t >= 5);
      s[1] = (t >= 8);
      s[3] = (t >= 10);
      cycle(1'b1, 4'b1011, s);
      check_eq("s1_valvula2_off", valv[2], 1'b0);
      if (t == 1)  check_eq("s1_valves_open", valv, 4'b1011);
      if (t == 9)  check_eq("s1_ch0_closed", valv[0], 1'b0);
      if (t == 12) check_eq("s1_ch1_closed", valv[1], 1'b0);
      if (t == 13) check_eq("s1_tarefa_before", tar, 1'b0);
      if (t == 14) check_eq("s1_tarefa_after", tar, 1'b1);
    end
    idle(2);
  endtask

  logic [N-1:0] rm, rs;
  int           rlen;
  int           rise [N];
  logic [8*8-1:0] glitch;

  initial begin
    model_reset();
    reset = 1'b1;
    cmd = 1'b0; hab = '0; sens = '0;
    @(posedge clk); #1;
    check_eq("reset_valvula", valv, '0);
    check_eq("reset_tarefa", tar, 1'b0);
    check_eq("reset_erro", etmo, 1'b0);
    check_eq("reset_canal_erro", cerr, '0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // 1: three channels fill with staggered sensor rises.
    scen1();

    // 2: glitch on ch0 must not close the valve.
    glitch = 64'h0;
    for (int t = 0; t < 14; t++) begin
      rs = '0;
      // pattern 1,1,1,0,1,1,1,1 from t=2, then stays 1
      if (t >= 2) rs[0] = !(t == 5);
      cycle(1'b1, 4'b0001, rs);
      if (t == 6) check_eq("s2_valve_through_glitch", valv[0], 1'b1);
      if (t == 9) check_eq("s2_valve_before_close", valv[0], 1'b1);
      if (t == 10) check_eq("s2_valve_closed", valv[0], 1'b0);
    end
    idle(2);

    // 3: ch1 never fills and times out.
    for (int t = 0; t < 24; t++) begin
      rs = (t >= 3) ? 4'b1101 : 4'b0000;
      cycle(1'b1, 4'b1111, rs);
      if (t == 20) check_eq("s3_ch1_still_open", valv[1], 1'b1);
      if (t == 20) check_eq("s3_no_error_yet", cerr, 4'b0000);
      if (t == 21) begin
        check_eq("s3_ch1_closed", valv[1], 1'b0);
        check_eq("s3_canal_erro", cerr, 4'b0010);
        check_eq("s3_erro_timeout", etmo, 1'b1);
        check_eq("s3_tarefa", tar, 1'b1);
      end
    end
    idle(2);

    // 4: abort mid-fill, then a new cycle with only ch2.
    for (int t = 0; t < 8; t++) begin
      cycle(t < 6, 4'b1111, 4'b0000);
      if (t == 7) check_eq("s4_all_closed", valv, 4'b0000);
      check_eq("s4_no_tarefa", tar, 1'b0);
    end
    for (int t = 0; t < 12; t++) begin
      rs = (t >= 3) ? 4'b1111 : 4'b0000;
      cycle(1'b1, (t == 0) ? 4'b0100 : 4'b1111, rs);
      if (t == 2) check_eq("s4_only_ch2", valv, 4'b0100);
    end
    idle(2);

    // 5: empty mask completes immediately.
    for (int t = 0; t < 4; t++) begin
      cycle(t < 3, 4'b0000, 4'b1111);
      if (t == 0) check_eq("s5_tarefa_latch_edge", tar, 1'b0);
      if (t == 1) check_eq("s5_tarefa_set", tar, 1'b1);
      if (t == 3) check_eq("s5_tarefa_cleared", tar, 1'b0);
      check_eq("s5_no_valve", valv, 4'b0000);
    end
    idle(1);

    // 6: async reset while an error is flagged, then scenario 1 again.
    for (int t = 0; t < 23; t++) begin
      rs = (t >= 2) ? 4'b1101 : 4'b0000;
      cycle(1'b1, 4'b1111, rs);
    end
    check_eq("s6_error_before_reset", cerr, 4'b0010);
    #3;
    reset = 1'b1;
    cmd   = 1'b0;
    #2;
    check_eq("s6_async_valvula", valv, '0);
    check_eq("s6_async_canal_erro", cerr, '0);
    check_eq("s6_async_erro", etmo, 1'b0);
    check_eq("s6_async_tarefa", tar, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    scen1();

    // Randomized fill cycles: random masks, rise times, glitches and lengths.
    for (int trial = 0; trial < 40; trial++) begin
      rm   = N'($urandom);
      rlen = $urandom_range(3, 35);
      for (int i = 0; i < N; i++) rise[i] = $urandom_range(0, 28);
      for (int t = 0; t < rlen; t++) begin
        for (int i = 0; i < N; i++) begin
          if (t >= rise[i]) rs[i] = ($urandom_range(0, 15) != 0);
          else              rs[i] = ($urandom_range(0, 3) == 0);
        end
        cycle(1'b1, (t == 0) ? rm : N'($urandom), rs);
      end
      for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
        cycle(1'b0, N'($urandom), N'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
